// File: rtl/mrh_l2_req_arbiter.sv
// Tile-level L2 request arbiter: round-robin grant of REQ_NUM L1 requesters into a
// one-entry output register with per-requester outstanding limits, plus
// combinational response routing by the source id carried in the upper tag bits.
module mrh_l2_req_arbiter #(
  parameter int REQ_NUM   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [REQ_NUM-1:0]        i_req_valid,
  output logic [REQ_NUM-1:0]        o_req_ready,
  input  logic [2*REQ_NUM-1:0]      i_req_cmd,
  input  logic [ADDR_W*REQ_NUM-1:0] i_req_addr,
  input  logic [TAG_W*REQ_NUM-1:0]  i_req_tag,
  input  logic [DATA_W*REQ_NUM-1:0] i_req_data,
  output logic                      o_l2_req_valid,
  input  logic                      i_l2_req_ready,
  output logic [1:0]                o_l2_req_cmd,
  output logic [ADDR_W-1:0]         o_l2_req_addr,
  output logic [TAG_W+1:0]          o_l2_req_tag,
  output logic [DATA_W-1:0]         o_l2_req_data,
  input  logic                      i_l2_resp_valid,
  output logic                      o_l2_resp_ready,
  input  logic [TAG_W+1:0]          i_l2_resp_tag,
  input  logic [DATA_W-1:0]         i_l2_resp_data,
  output logic [REQ_NUM-1:0]        o_resp_valid,
  input  logic [REQ_NUM-1:0]        i_resp_ready,
  output logic [TAG_W-1:0]          o_resp_tag,
  output logic [DATA_W-1:0]         o_resp_data,
  output logic                      o_bad_resp
);

  localparam logic [3:0] MAX_CNT   = 4'(MAX_OUTST);
  localparam logic [2:0] REQ_NUM_L = 3'(REQ_NUM);
  localparam logic [1:0] LAST_IDX  = 2'(REQ_NUM - 1);

  logic [1:0]              ptr_reg, ptr_next;
  logic [REQ_NUM-1:0][3:0] cnt_reg, cnt_next;
  logic [REQ_NUM-1:0]      eligible, grant_vec, resp_sel, resp_fire;
  logic                    slot_free, grant_any;
  logic [1:0]              win_idx;
  logic [1:0]              resp_id;
  logic                    id_ok;

  logic                    valid_reg, bad_reg;
  logic [1:0]              cmd_reg, sel_cmd;
  logic [ADDR_W-1:0]       addr_reg, sel_addr;
  logic [TAG_W+1:0]        tag_reg, sel_tag;
  logic [DATA_W-1:0]       data_reg, sel_data;

  // Requesters see no ready while reset is held, so nothing is accepted into a cleared slot.
  assign slot_free = i_reset_n & (~valid_reg | i_l2_req_ready);
  assign resp_id   = i_l2_resp_tag[TAG_W+1:TAG_W];
  assign id_ok     = {1'b0, resp_id} < REQ_NUM_L;

  // Per-requester eligibility, response steering and outstanding-count update.
  generate
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_req
      logic inc, dec;
      assign eligible[gi]     = i_req_valid[gi] & (cnt_reg[gi] < MAX_CNT);
      assign resp_sel[gi]     = id_ok & (resp_id == 2'(gi));
      assign o_resp_valid[gi] = i_l2_resp_valid & resp_sel[gi];
      assign resp_fire[gi]    = o_resp_valid[gi] & i_resp_ready[gi];
      assign inc              = grant_vec[gi];
      // A response against an empty counter is a stray and must not wrap.
      assign dec              = resp_fire[gi] & (cnt_reg[gi] != 4'd0);
      assign cnt_next[gi]     = (inc & ~dec) ? cnt_reg[gi] + 4'd1 :
                                (dec & ~inc) ? cnt_reg[gi] - 4'd1 : cnt_reg[gi];
    end
  endgenerate

  // Round-robin search: first pass covers pointer..top, second pass wraps to the bottom.
  always_comb begin
    logic found;
    found     = 1'b0;
    grant_vec = '0;
    win_idx   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!found && eligible[i] && (i >= int'(ptr_reg))) begin
        found   = 1'b1;
        win_idx = 2'(i);
      end
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!found && eligible[i]) begin
        found   = 1'b1;
        win_idx = 2'(i);
      end
    end
    grant_any = found & slot_free;
    if (grant_any) grant_vec[win_idx] = 1'b1;
  end

  assign o_req_ready = grant_vec;
  assign ptr_next    = grant_any ? ((win_idx == LAST_IDX) ? 2'd0 : win_idx + 2'd1) : ptr_reg;

  // Payload mux for the granted requester; the source id is prepended to its local tag.
  always_comb begin
    sel_cmd  = '0;
    sel_addr = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant_vec[i]) begin
        sel_cmd  = i_req_cmd[i*2 +: 2];
        sel_addr = i_req_addr[i*ADDR_W +: ADDR_W];
        sel_tag  = {2'(i), i_req_tag[i*TAG_W +: TAG_W]};
        sel_data = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output slot, round-robin pointer, outstanding counters and bad-response pulse.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_reg <= 1'b0;
      cmd_reg   <= '0;
      addr_reg  <= '0;
      tag_reg   <= '0;
      data_reg  <= '0;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      bad_reg   <= 1'b0;
    end else begin
      if (slot_free) begin
        valid_reg <= grant_any;
        if (grant_any) begin
          cmd_reg  <= sel_cmd;
          addr_reg <= sel_addr;
          tag_reg  <= sel_tag;
          data_reg <= sel_data;
        end
      end
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
      bad_reg <= i_l2_resp_valid & ~id_ok;
    end
  end

  assign o_l2_req_valid  = valid_reg;
  assign o_l2_req_cmd    = cmd_reg;
  assign o_l2_req_addr   = addr_reg;
  assign o_l2_req_tag    = tag_reg;
  assign o_l2_req_data   = data_reg;
  // Unknown ids are always accepted so a corrupt response cannot stall the L2 channel.
  assign o_l2_resp_ready = id_ok ? |(resp_sel & i_resp_ready) : 1'b1;
  assign o_resp_tag      = i_l2_resp_tag[TAG_W-1:0];
  assign o_resp_data     = i_l2_resp_data;
  assign o_bad_resp      = bad_reg;

endmodule

// File: tb/tb_mrh_l2_req_arbiter.sv
// Self-checking bench for mrh_l2_req_arbiter (REQ_NUM=2, MAX_OUTST=4).
module tb_mrh_l2_req_arbiter;

  localparam int REQ_NUM = 2, ADDR_W = 32, DATA_W = 64, TAG_W = 4, MAX_OUTST = 4;

  logic                      i_clk = 1'b0;
  logic                      i_reset_n;
  logic [REQ_NUM-1:0]        i_req_valid, o_req_ready;
  logic [2*REQ_NUM-1:0]      i_req_cmd;
  logic [ADDR_W*REQ_NUM-1:0] i_req_addr;
  logic [TAG_W*REQ_NUM-1:0]  i_req_tag;
  logic [DATA_W*REQ_NUM-1:0] i_req_data;
  logic                      o_l2_req_valid, i_l2_req_ready;
  logic [1:0]                o_l2_req_cmd;
  logic [ADDR_W-1:0]         o_l2_req_addr;
  logic [TAG_W+1:0]          o_l2_req_tag;
  logic [DATA_W-1:0]         o_l2_req_data;
  logic                      i_l2_resp_valid, o_l2_resp_ready;
  logic [TAG_W+1:0]          i_l2_resp_tag;
  logic [DATA_W-1:0]         i_l2_resp_data;
  logic [REQ_NUM-1:0]        o_resp_valid, i_resp_ready;
  logic [TAG_W-1:0]          o_resp_tag;
  logic [DATA_W-1:0]         o_resp_data;
  logic                      o_bad_resp;

  always #5 i_clk = ~i_clk;

  mrh_l2_req_arbiter #(.REQ_NUM(REQ_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .TAG_W(TAG_W), .MAX_OUTST(MAX_OUTST)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_cmd(i_req_cmd),
    .i_req_addr(i_req_addr), .i_req_tag(i_req_tag), .i_req_data(i_req_data),
    .o_l2_req_valid(o_l2_req_valid), .i_l2_req_ready(i_l2_req_ready),
    .o_l2_req_cmd(o_l2_req_cmd), .o_l2_req_addr(o_l2_req_addr),
    .o_l2_req_tag(o_l2_req_tag), .o_l2_req_data(o_l2_req_data),
    .i_l2_resp_valid(i_l2_resp_valid), .o_l2_resp_ready(o_l2_resp_ready),
    .i_l2_resp_tag(i_l2_resp_tag), .i_l2_resp_data(i_l2_resp_data),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_tag(o_resp_tag), .o_resp_data(o_resp_data), .o_bad_resp(o_bad_resp)
  );

  typedef struct {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W+1:0]  tag;
    logic [DATA_W-1:0] data;
  } sb_t;

  typedef struct {
    logic       rv;
    logic [5:0] tag;
    logic [1:0] rr;
    logic [1:0] exp_rv;
    logic       exp_l2r;
    logic       exp_bad;
  } vec_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [1:0] cmd, input logic [31:0] addr,
                          input logic [3:0] tag, input logic [63:0] data);
    i_req_cmd[p*2 +: 2]           = cmd;
    i_req_addr[p*ADDR_W +: ADDR_W] = addr;
    i_req_tag[p*TAG_W +: TAG_W]   = tag;
    i_req_data[p*DATA_W +: DATA_W] = data;
  endtask

  // Expect port p to win this cycle and queue the request the L2 side must see.
  task automatic expect_grant(input int p);
    logic [1:0] exp_r;
    sb_t e;
    exp_r    = '0;
    exp_r[p] = 1'b1;
    check("req_ready_grant", 64'(o_req_ready), 64'(exp_r));
    e.cmd  = i_req_cmd[p*2 +: 2];
    e.addr = i_req_addr[p*ADDR_W +: ADDR_W];
    e.tag  = {2'(p), i_req_tag[p*TAG_W +: TAG_W]};
    e.data = i_req_data[p*DATA_W +: DATA_W];
    sb_q.push_back(e);
  endtask

  task automatic expect_none();
    check("req_ready_none", 64'(o_req_ready), 64'd0);
  endtask

  task automatic check_resp(input logic [1:0] rv, input logic l2r, input logic [3:0] tag);
    check("resp_valid", 64'(o_resp_valid), 64'(rv));
    check("l2_resp_ready", 64'(o_l2_resp_ready), 64'(l2r));
    check("resp_tag", 64'(o_resp_tag), 64'(tag));
  endtask

  // L2-side monitor: payload must match the oldest expected entry while valid; pop on accept.
  always @(negedge i_clk) begin
    if (i_reset_n && o_l2_req_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty actual=valid required=no_request at %0t", $time);
      end else begin
        mon_e = sb_q[0];
        check("l2_cmd", 64'(o_l2_req_cmd), 64'(mon_e.cmd));
        check("l2_addr", 64'(o_l2_req_addr), 64'(mon_e.addr));
        check("l2_tag", 64'(o_l2_req_tag), 64'(mon_e.tag));
        check("l2_data", o_l2_req_data, mon_e.data);
        if (i_l2_req_ready) begin
          $display("l2 accept tag=%02h addr=%08h cmd=%0d data=%0h",
                   o_l2_req_tag, o_l2_req_addr, o_l2_req_cmd, o_l2_req_data);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 6'h13, 2'b00, 2'b10, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 6'h13, 2'b10, 2'b10, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 6'h05, 2'b01, 2'b01, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 6'h05, 2'b10, 2'b01, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 6'h05, 2'b01, 2'b00, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 6'h3F, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 6'h2A, 2'b11, 2'b00, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 6'h3F, 2'b00, 2'b00, 1'b1, 1'b0};

    i_reset_n = 1'b0; i_req_valid = '0; i_req_cmd = '0; i_req_addr = '0;
    i_req_tag = '0; i_req_data = '0; i_l2_req_ready = 1'b1; i_l2_resp_valid = 1'b0;
    i_l2_resp_tag = '0; i_l2_resp_data = '0; i_resp_ready = '0;

    // Reset state
    next_cycle();
    #3;
    check("rst_l2_valid", 64'(o_l2_req_valid), 64'd0);
    check("rst_req_ready", 64'(o_req_ready), 64'd0);
    check("rst_bad_resp", 64'(o_bad_resp), 64'd0);
    check("rst_l2_tag", 64'(o_l2_req_tag), 64'd0);
    check("rst_l2_addr", 64'(o_l2_req_addr), 64'd0);
    next_cycle();
    i_reset_n = 1'b1;
    next_cycle();

    // Response routing table (request side idle)
    foreach (vecs[k]) begin
      i_l2_resp_valid = vecs[k].rv;
      i_l2_resp_tag   = vecs[k].tag;
      i_resp_ready    = vecs[k].rr;
      i_l2_resp_data  = 64'hD000 + 64'(k);
      #3;
      check_resp(vecs[k].exp_rv, vecs[k].exp_l2r, vecs[k].tag[3:0]);
      check("resp_data", o_resp_data, 64'hD000 + 64'(k));
      next_cycle();
      check("bad_resp", 64'(o_bad_resp), 64'(vecs[k].exp_bad));
    end
    i_l2_resp_valid = 1'b0;
    i_resp_ready    = '0;

    // Alternating grants with both ports busy
    i_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      set_port(0, 2'd0, 32'h1000 + 32'(k), 4'h3, 64'hA0 + 64'(k));
      set_port(1, 2'd1, 32'h2000 + 32'(k), 4'h5, 64'hB0 + 64'(k));
      #3;
      expect_grant(k % 2);
      next_cycle();
      if (k == 1) check("port1_tag_0x15", 64'(o_l2_req_tag), 64'h15);
    end
    i_req_valid = '0;
    #3;
    expect_none();
    next_cycle();
    next_cycle();

    // Reset asserted mid-stream
    i_req_valid = 2'b11;
    #3;
    expect_grant(0);
    next_cycle();
    i_reset_n = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 2; k++) begin
      #3;
      check("midrst_l2_valid", 64'(o_l2_req_valid), 64'd0);
      check("midrst_req_ready", 64'(o_req_ready), 64'd0);
      next_cycle();
    end
    i_reset_n = 1'b1;
    #3;
    expect_grant(0);
    next_cycle();
    i_req_valid = '0;
    #3;
    next_cycle();

    // Output stall: payload held while L2 is not ready
    set_port(0, 2'd1, 32'hCAFE0000, 4'h7, 64'h1111);
    i_req_valid    = 2'b01;
    i_l2_req_ready = 1'b0;
    #3;
    expect_grant(0);
    next_cycle();
    set_port(0, 2'd0, 32'hBEEF0000, 4'h8, 64'h2222);
    for (int k = 0; k < 5; k++) begin
      #3;
      expect_none();
      check("stall_l2_valid", 64'(o_l2_req_valid), 64'd1);
      next_cycle();
    end
    i_l2_req_ready = 1'b1;
    #3;
    expect_grant(0);
    next_cycle();
    i_req_valid = '0;
    #3;
    next_cycle();

    // Outstanding limit on port 0
    i_reset_n = 1'b0;
    sb_q.delete();
    next_cycle();
    i_reset_n   = 1'b1;
    i_req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      set_port(0, 2'd0, 32'h3000 + 32'(k), 4'(k), 64'hC0 + 64'(k));
      #3;
      expect_grant(0);
      next_cycle();
    end
    set_port(0, 2'd0, 32'h3004, 4'h4, 64'hC4);
    set_port(1, 2'd1, 32'h4000, 4'h9, 64'hE0);
    i_req_valid = 2'b11;
    #3;
    expect_grant(1);
    next_cycle();
    i_req_valid     = 2'b01;
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag   = 6'h0A;
    i_resp_ready    = 2'b01;
    #3;
    expect_none();
    check_resp(2'b01, 1'b1, 4'hA);
    next_cycle();
    i_l2_resp_valid = 1'b0;
    i_resp_ready    = '0;
    #3;
    expect_grant(0);
    next_cycle();
    i_req_valid = '0;
    #3;
    next_cycle();

    // Response held until requester 1 is ready, then its counter drops to 0
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag   = 6'h13;
    i_resp_ready    = 2'b00;
    for (int k = 0; k < 2; k++) begin
      #3;
      check_resp(2'b10, 1'b0, 4'h3);
      next_cycle();
    end
    i_resp_ready = 2'b10;
    #3;
    check_resp(2'b10, 1'b1, 4'h3);
    next_cycle();
    i_l2_resp_valid = 1'b0;
    i_resp_ready    = '0;
    i_req_valid     = 2'b10;
    for (int k = 0; k < 4; k++) begin
      set_port(1, 2'd0, 32'h5000 + 32'(k), 4'hE, 64'hF0 + 64'(k));
      #3;
      expect_grant(1);
      next_cycle();
    end
    #3;
    expect_none();
    next_cycle();
    i_req_valid = '0;

    // Unknown source id pulses bad_resp for exactly one cycle
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag   = 6'h3F;
    #3;
    check_resp(2'b00, 1'b1, 4'hF);
    next_cycle();
    i_l2_resp_valid = 1'b0;
    check("bad_pulse", 64'(o_bad_resp), 64'd1);
    #3;
    next_cycle();
    check("bad_clear", 64'(o_bad_resp), 64'd0);

    // Free one port-0 slot, then grant and response in the same cycle leave it at 3
    i_l2_resp_valid = 1'b1;
    i_l2_resp_tag   = 6'h01;
    i_resp_ready    = 2'b01;
    #3;
    check_resp(2'b01, 1'b1, 4'h1);
    next_cycle();
    i_l2_resp_tag = 6'h02;
    i_req_valid   = 2'b01;
    set_port(0, 2'd2, 32'h6000, 4'hB, 64'h77);
    #3;
    expect_grant(0);
    next_cycle();
    i_l2_resp_valid = 1'b0;
    i_resp_ready    = '0;
    set_port(0, 2'd3, 32'h6001, 4'hC, 64'h78);
    #3;
    expect_grant(0);
    next_cycle();
    #3;
    expect_none();
    next_cycle();
    i_req_valid = '0;
    next_cycle();
    next_cycle();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
